stopwatch_core: RTL and testbench

//  Stopwatch consuming the divider's toggling 100 Hz line and 2-bit scan select.

---
 rtl/stopwatch_core.sv | 190 +++++++++++++++++++
 tb/tb_stopwatch_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - SS.CC BCD stopwatch with start/pause, lap freeze, clear
// and a scanned 4-digit seven-segment driver.
module stopwatch_core #(
   parameter int SEC_TENS_MAX = 5,
   parameter int DP_DIGIT     = 2
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        tick_100hz,
   input  logic [1:0]  scan_sel,
   input  logic        btn_start_stop,
   input  logic        btn_lap_clr,
   output logic        running,
   output logic [15:0] disp_bcd,
   output logic        wrap_pulse,
   output logic [3:0]  ssd_ctl,
   output logic [7:0]  ssd_out
);

   localparam logic [3:0] ST_MAX = SEC_TENS_MAX[3:0];
   localparam logic [1:0] DP_SEL = DP_DIGIT[1:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_LAP   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        lap_capture;
   logic        clear_cnt;

   logic        tick_d;
   logic        tick_en;
   logic        count_en;

   logic [3:0]  cs_o, cs_t, s_o, s_t;
   logic [3:0]  cs_o_n, cs_t_n, s_o_n, s_t_n;
   logic        wrap_n;
   logic [15:0] lap_reg;
   logic [3:0]  digit;

   // Both edges of the divider line are 10 ms apart.
   assign tick_en  = tick_100hz ^ tick_d;
   assign running  = (state_q == S_RUN) || (state_q == S_LAP);
   assign count_en = tick_en && running;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Start has priority over lap when both pulse together.
   always_comb begin
      state_d     = state_q;
      lap_capture = 1'b0;
      clear_cnt   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (btn_start_stop) state_d = S_RUN;
         end
         S_RUN: begin
            if (btn_start_stop) begin
               state_d = S_PAUSE;
            end else if (btn_lap_clr) begin
               state_d     = S_LAP;
               lap_capture = 1'b1;
            end
         end
         S_LAP: begin
            if (btn_start_stop) begin
               state_d = S_PAUSE;
            end else if (btn_lap_clr) begin
               state_d = S_RUN;
            end
         end
         S_PAUSE: begin
            if (btn_start_stop) begin
               state_d = S_RUN;
            end else if (btn_lap_clr) begin
               state_d   = S_IDLE;
               clear_cnt = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cs_o_n = cs_o;
      cs_t_n = cs_t;
      s_o_n  = s_o;
      s_t_n  = s_t;
      wrap_n = 1'b0;
      if (clear_cnt) begin
         cs_o_n = 4'd0;
         cs_t_n = 4'd0;
         s_o_n  = 4'd0;
         s_t_n  = 4'd0;
      end else if (count_en) begin
         if (cs_o == 4'd9) begin
            cs_o_n = 4'd0;
            if (cs_t == 4'd9) begin
               cs_t_n = 4'd0;
               if (s_o == 4'd9) begin
                  s_o_n = 4'd0;
                  if (s_t == ST_MAX) begin
                     s_t_n  = 4'd0;
                     wrap_n = 1'b1;
                  end else begin
                     s_t_n = s_t + 4'd1;
                  end
               end else begin
                  s_o_n = s_o + 4'd1;
               end
            end else begin
               cs_t_n = cs_t + 4'd1;
            end
         end else begin
            cs_o_n = cs_o + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         tick_d     <= 1'b0;
         cs_o       <= 4'd0;
         cs_t       <= 4'd0;
         s_o        <= 4'd0;
         s_t        <= 4'd0;
         wrap_pulse <= 1'b0;
         lap_reg    <= 16'h0000;
         disp_bcd   <= 16'h0000;
      end else begin
         tick_d     <= tick_100hz;
         cs_o       <= cs_o_n;
         cs_t       <= cs_t_n;
         s_o        <= s_o_n;
         s_t        <= s_t_n;
         wrap_pulse <= wrap_n;
         if (lap_capture) begin
            lap_reg <= {s_t, s_o, cs_t, cs_o};
         end
         disp_bcd <= (state_q == S_LAP) ? lap_reg : {s_t, s_o, cs_t, cs_o};
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      digit = 4'd0;
      case (scan_sel)
         2'd0:    digit = disp_bcd[3:0];
         2'd1:    digit = disp_bcd[7:4];
         2'd2:    digit = disp_bcd[11:8];
         2'd3:    digit = disp_bcd[15:12];
         default: digit = 4'd0;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         ssd_ctl <= 4'b1111;
         ssd_out <= 8'hFF;
      end else begin
         ssd_ctl <= ~(4'b0001 << scan_sel);
         ssd_out <= {seg7(digit), (scan_sel != DP_SEL)};
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core against a
// centisecond-integer reference model.
module tb_stopwatch_core;

   logic        clk_in = 1'b0;
   logic        rst = 1'b0;
   logic        tick_100hz = 1'b0;
   logic [1:0]  scan_sel = 2'd0;
   logic        btn_start_stop = 1'b0;
   logic        btn_lap_clr = 1'b0;
   logic        running;
   logic [15:0] disp_bcd;
   logic        wrap_pulse;
   logic [3:0]  ssd_ctl;
   logic [7:0]  ssd_out;

   int errors = 0;
   int checks = 0;

   localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
   int         m_st, m_cnt, m_lap, m_disp;
   logic       m_wrap, m_tprev;
   logic [3:0] m_ctl;
   logic [7:0] m_seg;
   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

   stopwatch_core dut (
      .clk_in(clk_in), .rst(rst), .tick_100hz(tick_100hz), .scan_sel(scan_sel),
      .btn_start_stop(btn_start_stop), .btn_lap_clr(btn_lap_clr),
      .running(running), .disp_bcd(disp_bcd), .wrap_pulse(wrap_pulse),
      .ssd_ctl(ssd_ctl), .ssd_out(ssd_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int digit_of(input int v, input int idx);
      int p = 1;
      for (int i = 0; i < idx; i++) p = p * 10;
      return (v / p) % 10;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = 0; m_lap = 0; m_disp = 0;
      m_wrap = 1'b0; m_tprev = 1'b0; m_ctl = 4'b1111; m_seg = 8'hFF;
   endtask

   // One clock edge of the stopwatch, described in centiseconds.
   task automatic model_edge();
      int  nst = m_st, ncnt = m_cnt, nlap = m_lap;
      logic tick_ev = tick_100hz ^ m_tprev;
      m_wrap = 1'b0;
      if ((m_st == M_RUN || m_st == M_LAP) && tick_ev) begin
         m_wrap = (m_cnt == 5999);
         ncnt = (m_cnt + 1) % 6000;
      end
      case (m_st)
         M_IDLE:  if (btn_start_stop) nst = M_RUN;
         M_RUN:   if (btn_start_stop) nst = M_PAUSE;
                  else if (btn_lap_clr) begin nst = M_LAP; nlap = m_cnt; end
         M_LAP:   if (btn_start_stop) nst = M_PAUSE;
                  else if (btn_lap_clr) nst = M_RUN;
         default: if (btn_start_stop) nst = M_RUN;
                  else if (btn_lap_clr) begin nst = M_IDLE; ncnt = 0; end
      endcase
      m_ctl  = ~(4'b0001 << scan_sel);
      m_seg  = {seg_tab[digit_of(m_disp, int'(scan_sel))], scan_sel != 2'd2};
      m_disp = (m_st == M_LAP) ? m_lap : m_cnt;
      m_st = nst; m_cnt = ncnt; m_lap = nlap; m_tprev = tick_100hz;
   endtask

   task automatic step(input logic s, input logic l, input logic t);
      btn_start_stop = s;
      btn_lap_clr    = l;
      if (t) tick_100hz = ~tick_100hz;
      @(posedge clk_in);
      model_edge();
      #1;
      btn_start_stop = 1'b0;
      btn_lap_clr    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", running); end
      checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL reset_disp got=%h want=0000", disp_bcd); end
      checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b want=0", wrap_pulse); end
      checks++; if (ssd_ctl !== 4'b1111) begin errors++; $display("FAIL reset_ctl got=%b want=1111", ssd_ctl); end
      checks++; if (ssd_out !== 8'hFF) begin errors++; $display("FAIL reset_seg got=%h want=ff", ssd_out); end
   endtask

   task automatic test_count_150();
      do_reset();
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL start_tick_counted got=%h want=0000", disp_bcd); end
      for (int i = 0; i < 150; i++) begin
         step(1'b0, 1'b0, 1'b1);
         repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0150) begin errors++; $display("FAIL count150_disp got=%h want=0150", disp_bcd); end
      checks++; if (disp_bcd !== to_bcd(m_disp)) begin errors++; $display("FAIL count150_model got=%h want=%h", disp_bcd, to_bcd(m_disp)); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL count150_running got=%b want=1", running); end
   endtask

   task automatic test_wrap();
      int highs = 0;
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      ticks(5998);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h5998) begin errors++; $display("FAIL wrap_preload got=%h want=5998", disp_bcd); end
      step(1'b0, 1'b0, 1'b1);
      if (wrap_pulse === 1'b1) highs++;
      step(1'b0, 1'b0, 1'b1);
      checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL wrap_edge got=%b want=1", wrap_pulse); end
      if (wrap_pulse === 1'b1) highs++;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (wrap_pulse === 1'b1) highs++;
      end
      checks++; if (highs != 1) begin errors++; $display("FAIL wrap_width got=%0d want=1 cycles", highs); end
      checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL wrap_disp got=%h want=0000", disp_bcd); end
   endtask

   task automatic test_lap();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      ticks(1234);
      step(1'b0, 1'b1, 1'b0);
      ticks(100);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h1234) begin errors++; $display("FAIL lap_frozen got=%h want=1234", disp_bcd); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running got=%b want=1", running); end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h1334) begin errors++; $display("FAIL lap_release got=%h want=1334", disp_bcd); end
   endtask

   task automatic test_pause_clear();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      ticks(307);
      step(1'b1, 1'b0, 1'b0);
      ticks(10);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0307) begin errors++; $display("FAIL pause_hold got=%h want=0307", disp_bcd); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got=%b want=0", running); end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL clear_disp got=%h want=0000", disp_bcd); end
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0000) begin errors++; $display("FAIL idle_lap_disp got=%h want=0000", disp_bcd); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_lap_running got=%b want=0", running); end
   endtask

   task automatic test_start_lap_same();
      int n = $urandom_range(50, 200);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      ticks(n);
      step(1'b1, 1'b1, 1'b1);
      ticks(5);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL both_running got=%b want=0", running); end
      checks++; if (disp_bcd !== to_bcd(n + 1)) begin errors++; $display("FAIL both_count got=%h want=%h", disp_bcd, to_bcd(n + 1)); end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         scan_sel = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
         checks++;
         if (disp_bcd !== to_bcd(m_disp) || running !== (m_st == M_RUN || m_st == M_LAP) ||
             wrap_pulse !== m_wrap || ssd_ctl !== m_ctl || ssd_out !== m_seg) begin
            errors++;
            if (bad < 5) $display("FAIL random_cycle%0d got=%h/%b/%b/%b/%h want=%h/%b/%b/%b/%h", i,
               disp_bcd, running, wrap_pulse, ssd_ctl, ssd_out,
               to_bcd(m_disp), (m_st == M_RUN || m_st == M_LAP), m_wrap, m_ctl, m_seg);
            bad++;
         end
      end
   endtask

   task automatic test_display_reset();
      logic [3:0] ctl_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [7:0] seg_exp [4] = '{8'h03, 8'h03, 8'h48, 8'h03};
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      ticks(500);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0500) begin errors++; $display("FAIL disp_0500 got=%h want=0500", disp_bcd); end
      for (int s = 0; s < 4; s++) begin
         scan_sel = 2'(s);
         step(1'b0, 1'b0, 1'b0);
         checks++; if (ssd_ctl !== ctl_exp[s]) begin errors++; $display("FAIL scan%0d_ctl got=%b want=%b", s, ssd_ctl, ctl_exp[s]); end
         checks++; if (ssd_out !== seg_exp[s]) begin errors++; $display("FAIL scan%0d_seg got=%h want=%h", s, ssd_out, seg_exp[s]); end
      end
      step(1'b1, 1'b0, 1'b0);
      ticks(37);
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (running !== 1'b0 || disp_bcd !== 16'h0000 || wrap_pulse !== 1'b0 ||
          ssd_ctl !== 4'b1111 || ssd_out !== 8'hFF) begin
         errors++;
         $display("FAIL midrun_reset got=%b/%h/%b/%b/%h want=0/0000/0/1111/ff",
                  running, disp_bcd, wrap_pulse, ssd_ctl, ssd_out);
      end
      @(negedge clk_in);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      checks++; if (disp_bcd !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL post_reset got=%h/%b want=0000/0", disp_bcd, running); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_count_150();
      test_wrap();
      test_lap();
      test_pause_clear();
      test_start_lap_same();
      test_random();
      test_display_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
